// File: rtl/ram_pkg.sv
// Shared command encodings and default geometry for the SPI-slave storage back end.
// Imported by ram_if, ram_mem and ram.
package ram_pkg;
  localparam int RAM_DEPTH = 256;
  localparam int RAM_WIDTH = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } ram_cmd_t;
endpackage

// File: rtl/ram_if.sv
// Command/data word bus between the SPI slave (master) and the ram (slave).
// din = {cmd[1:0], payload}; dout/tx_valid carry registered read data back.
interface ram_if #(
  parameter int MEM_WIDTH = ram_pkg::RAM_WIDTH
);
  logic [MEM_WIDTH+1:0] din;
  logic                 rx_valid;
  logic [MEM_WIDTH-1:0] dout;
  logic                 tx_valid;

  modport master (output din, output rx_valid, input dout, input tx_valid);
  modport slave  (input din, input rx_valid, output dout, output tx_valid);
endinterface

// File: rtl/ram_mem.sv
// Storage array with a synchronous write port and a registered read port. Latency 1 cycle.
// No backpressure: a write or read enable is honoured on every edge; only the read register resets.
module ram_mem #(
  parameter int DEPTH = ram_pkg::RAM_DEPTH,
  parameter int WIDTH = ram_pkg::RAM_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Array is deliberately left out of reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ram.sv
// 256x8 command-driven memory for the SPI slave; RAM_AUTOINC_EN adds post-access address increment.
// RD_DATA -> dout/tx_valid one cycle later; no backpressure, every valid word is consumed.
module ram
  import ram_pkg::*;
#(
  parameter int MEM_DEPTH = RAM_DEPTH,
  parameter int MEM_WIDTH = RAM_WIDTH
) (
  input logic  clk,
  input logic  rst,
  ram_if.slave bus
);
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH);

  ram_cmd_t               cmd;
  logic [MEM_WIDTH-1:0]   payload;
  logic [ADDR_SIZE-1:0]   wr_addr;
  logic [ADDR_SIZE-1:0]   rd_addr;
  logic                   wr_en;
  logic                   rd_en;
  logic                   tx_valid_q;
  logic [MEM_WIDTH-1:0]   rd_data;

  assign cmd     = ram_cmd_t'(bus.din[MEM_WIDTH +: 2]);
  assign payload = bus.din[MEM_WIDTH-1:0];

  // Reset dominates rx_valid, so a word arriving during reset must not touch the array.
  always_comb begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (bus.rx_valid && !rst) begin
      wr_en = (cmd == CMD_WR_DATA);
      rd_en = (cmd == CMD_RD_DATA);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= rd_en;
      if (bus.rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= payload[ADDR_SIZE-1:0];
          CMD_RD_ADDR: rd_addr <= payload[ADDR_SIZE-1:0];
`ifdef RAM_AUTOINC_EN
          CMD_WR_DATA: wr_addr <= wr_addr + ADDR_SIZE'(1);
          CMD_RD_DATA: rd_addr <= rd_addr + ADDR_SIZE'(1);
`else
          default: ;
`endif
        endcase
      end
    end
  end

  ram_mem #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (MEM_WIDTH),
    .AW    (ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (payload),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign bus.dout     = rd_data;
  assign bus.tx_valid = tx_valid_q;
endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: reset, command decode, tx_valid pulsing, gating and address handling.
module tb_ram;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef RAM_AUTOINC_EN
  localparam logic [7:0] B2B_SECOND = 8'hA1;
`else
  localparam logic [7:0] B2B_SECOND = 8'hFF;
`endif

  ram_if #(.MEM_WIDTH(8)) bus ();

  ram #(.MEM_DEPTH(256), .MEM_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic r, input logic v, input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    rst          = r;
    bus.rx_valid = v;
    bus.din      = {c, p};
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] c, input logic [7:0] p);
    issue(1'b0, 1'b1, c, p);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    bus.rx_valid = 1'b1;
    bus.din      = 10'h3FF;

    // Reset with a valid RD_DATA word present.
    issue(1'b1, 1'b1, 2'b11, 8'hFF);
    issue(1'b1, 1'b1, 2'b11, 8'hFF);
    chk8("reset_dout", bus.dout, 8'h00);
    chk1("reset_tx_valid", bus.tx_valid, 1'b0);

    cmd(CMD_WR_DATA, 8'h5A);
    chk1("wr_data_tx_low", bus.tx_valid, 1'b0);
    cmd(CMD_RD_DATA, 8'h00);
    chk8("rd_after_reset_dout", bus.dout, 8'h5A);
    chk1("rd_after_reset_tx", bus.tx_valid, 1'b1);

    // Move both addresses away from 0, then reset with a WR_DATA word on the bus.
    cmd(CMD_WR_ADDR, 8'h07);
    cmd(CMD_RD_ADDR, 8'h07);
    cmd(CMD_WR_DATA, 8'h77);
    issue(1'b1, 1'b1, 2'b11, 8'hFF);
    chk8("reset2_dout", bus.dout, 8'h00);
    chk1("reset2_tx_valid", bus.tx_valid, 1'b0);
    issue(1'b1, 1'b1, 2'b01, 8'hC3);
    cmd(CMD_RD_DATA, 8'h00);
    chk8("reset_no_write_rd_addr0", bus.dout, 8'h5A);
    cmd(CMD_WR_DATA, 8'h66);
    cmd(CMD_RD_ADDR, 8'h07);
    cmd(CMD_RD_DATA, 8'h00);
    chk8("mem_retained_over_reset", bus.dout, 8'h77);
    cmd(CMD_RD_ADDR, 8'h00);
    cmd(CMD_RD_DATA, 8'h00);
    chk8("wr_addr_reset_to_0", bus.dout, 8'h66);

    // Basic sequence; RD_DATA payload 0xAA must be ignored.
    cmd(CMD_WR_ADDR, 8'h00);
    cmd(CMD_WR_DATA, 8'hFF);
    cmd(CMD_RD_ADDR, 8'h00);
    cmd(CMD_RD_DATA, 8'hAA);
    chk8("basic_dout", bus.dout, 8'hFF);
    chk1("basic_tx", bus.tx_valid, 1'b1);
    cmd(CMD_WR_ADDR, 8'h00);
    chk1("pulse_tx_drop", bus.tx_valid, 1'b0);
    chk8("pulse_dout_hold", bus.dout, 8'hFF);
    issue(1'b0, 1'b0, 2'b11, 8'hFF);
    chk1("idle_rd_tx_low", bus.tx_valid, 1'b0);
    chk8("idle_dout_hold", bus.dout, 8'hFF);

    // Gated WR_DATA must not reach mem[0].
    issue(1'b0, 1'b0, 2'b01, 8'h55);
    chk1("gated_tx_low", bus.tx_valid, 1'b0);
    cmd(CMD_RD_ADDR, 8'h00);
    cmd(CMD_RD_DATA, 8'h00);
    chk8("gated_write_ignored", bus.dout, 8'hFF);

    // Back-to-back reads: tx_valid stays high.
    cmd(CMD_WR_ADDR, 8'h01);
    cmd(CMD_WR_DATA, 8'hA1);
    chk8("wr_dout_hold", bus.dout, 8'hFF);
    cmd(CMD_RD_ADDR, 8'h00);
    cmd(CMD_RD_DATA, 8'h00);
    chk8("b2b_first_dout", bus.dout, 8'hFF);
    chk1("b2b_first_tx", bus.tx_valid, 1'b1);
    cmd(CMD_RD_DATA, 8'h00);
    chk8("b2b_second_dout", bus.dout, B2B_SECOND);
    chk1("b2b_second_tx", bus.tx_valid, 1'b1);

    // Separate addresses.
    cmd(CMD_WR_ADDR, 8'h05);
    cmd(CMD_WR_DATA, 8'h12);
    cmd(CMD_WR_ADDR, 8'hFF);
    cmd(CMD_WR_DATA, 8'h34);
    cmd(CMD_RD_ADDR, 8'hFF);
    cmd(CMD_RD_DATA, 8'h00);
    chk8("addr_ff_dout", bus.dout, 8'h34);
    cmd(CMD_RD_ADDR, 8'h05);
    cmd(CMD_RD_DATA, 8'h00);
    chk8("addr_05_dout", bus.dout, 8'h12);

    // Read the cycle after a write to the same address.
    cmd(CMD_WR_ADDR, 8'h20);
    cmd(CMD_RD_ADDR, 8'h20);
    cmd(CMD_WR_DATA, 8'h9C);
    cmd(CMD_RD_DATA, 8'h00);
    chk8("read_after_write", bus.dout, 8'h9C);

    // Top-of-array wrap (explicit address steps when auto-increment is off).
    cmd(CMD_WR_ADDR, 8'hFF);
    cmd(CMD_WR_DATA, 8'h11);
`ifndef RAM_AUTOINC_EN
    cmd(CMD_WR_ADDR, 8'h00);
`endif
    cmd(CMD_WR_DATA, 8'h22);
    cmd(CMD_RD_ADDR, 8'hFF);
    cmd(CMD_RD_DATA, 8'h00);
    chk8("wrap_rd_ff", bus.dout, 8'h11);
`ifndef RAM_AUTOINC_EN
    cmd(CMD_RD_ADDR, 8'h00);
`endif
    cmd(CMD_RD_DATA, 8'h00);
    chk8("wrap_rd_00", bus.dout, 8'h22);
    chk1("wrap_tx", bus.tx_valid, 1'b1);

    issue(1'b0, 1'b0, 2'b00, 8'h00);
    chk1("final_tx_low", bus.tx_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
